// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    // Arbiter sequencing: grant slot, memory access cycle, response cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Which requester owns the outstanding access.
    typedef enum logic {
        SRC_F = 1'b0,
        SRC_D = 1'b1
    } src_e;

    localparam int unsigned DEF_MEM_WORDS  = 32'd1024;
    localparam int unsigned DEF_FAIR_LIMIT = 32'd2;

    // Unsigned compare of a word address against the implemented memory size.
    function automatic logic addr_oob(input logic [15:0] addr, input int unsigned words);
        return ({16'd0, addr} >= words);
    endfunction

endpackage

// File: rtl/mem_arb_fair.sv
// Fairness counter and priority pick: data wins unless fetch has been
// starved for FAIR_LIMIT consecutive data grants.
module mem_arb_fair
    import mem_arb_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic freq_i,
    input  logic dreq_i,
    input  logic gnt_en_i,
    output logic pick_f_o,
    output logic pick_d_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       at_limit_s;

    assign at_limit_s = (count_q >= 8'(FAIR_LIMIT));

    // One-hot pick and next fairness count.
    always_comb begin
        pick_f_o = 1'b0;
        pick_d_o = 1'b0;
        count_d  = count_q;
        if (gnt_en_i && freq_i && (!dreq_i || at_limit_s)) begin
            pick_f_o = 1'b1;
        end else if (gnt_en_i && dreq_i) begin
            pick_d_o = 1'b1;
        end else begin
            pick_f_o = 1'b0;
        end
        if (!freq_i || pick_f_o) begin
            count_d = 8'd0;
        end else if (pick_d_o && !at_limit_s) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Fairness count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) front end for the single-ported word memory.
// One access outstanding: grant -> ACCESS -> RESP, with a new grant allowed
// in the RESP cycle for one access every two cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = DEF_MEM_WORDS,
    parameter int unsigned FAIR_LIMIT = DEF_FAIR_LIMIT
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        FReq,
    input  logic [15:0] FAddr,
    output logic        FGnt,
    output logic        FValid,
    output logic [15:0] FData,
    output logic        FErr,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [15:0] DAddr,
    input  logic [15:0] DWData,
    output logic        DGnt,
    output logic        DValid,
    output logic [15:0] DData,
    output logic        DErr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemDIn,
    output logic        MemWE,
    input  logic [15:0] MemDOut,
    input  logic        MemOOB
);

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic        oob_q, oob_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        we_q, we_d;
    logic        gnt_en_s;
    logic        pick_f_s;
    logic        pick_d_s;
    logic        err_s;

    assign gnt_en_s = (state_q == IDLE) || (state_q == RESP);

    mem_arb_fair #(.FAIR_LIMIT(FAIR_LIMIT)) u_fair (
        .clk_i    (CLK),
        .rst_n_i  (Reset_n),
        .freq_i   (FReq),
        .dreq_i   (DReq),
        .gnt_en_i (gnt_en_s),
        .pick_f_o (pick_f_s),
        .pick_d_o (pick_d_s)
    );

    // Next state and memory port values; write enable lasts only the ACCESS cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        oob_d   = oob_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (pick_f_s) begin
                    state_d = ACCESS;
                    src_d   = SRC_F;
                    oob_d   = addr_oob(FAddr, MEM_WORDS);
                    addr_d  = FAddr;
                    din_d   = 16'd0;
                end else if (pick_d_s) begin
                    state_d = ACCESS;
                    src_d   = SRC_D;
                    oob_d   = addr_oob(DAddr, MEM_WORDS);
                    addr_d  = DAddr;
                    din_d   = DWData;
                    we_d    = DWrite & ~addr_oob(DAddr, MEM_WORDS);
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered memory port; reset drops MemWE at once.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            src_q   <= SRC_F;
            oob_q   <= 1'b0;
            addr_q  <= 16'd0;
            din_q   <= 16'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            oob_q   <= oob_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
        end
    end

    assign FGnt    = pick_f_s;
    assign DGnt    = pick_d_s;
    assign MemAddr = addr_q;
    assign MemDIn  = din_q;
    assign MemWE   = we_q;

    // Response decode: error forces data to zero.
    assign err_s  = oob_q | MemOOB;
    assign FValid = (state_q == RESP) && (src_q == SRC_F);
    assign DValid = (state_q == RESP) && (src_q == SRC_D);
    assign FErr   = FValid & err_s;
    assign DErr   = DValid & err_s;
    assign FData  = (FValid && !err_s) ? MemDOut : 16'd0;
    assign DData  = (DValid && !err_s) ? MemDOut : 16'd0;

endmodule
